// File: rtl/piso_tx_ctrl.sv
// rtl/piso_tx_ctrl.sv - control FSM that feeds an external PISO shift register and frames its serial output
// Define PISO_TX_PARITY_EN to append an even-parity bit of the held word after the data bits.
module piso_tx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  input  logic             tx_hold,
  output logic             piso_load,
  output logic [WIDTH-1:0] piso_d,
  output logic             piso_shift,
  input  logic             piso_sout,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic [15:0]      word_count
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_PARITY, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] hold_q;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [15:0]      wc_q;

  logic handshake;
  logic shift_now;
  logic last_data;
`ifdef PISO_TX_PARITY_EN
  logic par_now;
`endif

  // An abort in the same cycle suppresses that cycle's bit so a dropped frame never reports completion.
  always_comb begin
    in_ready   = reset & (state == S_IDLE);
    handshake  = in_valid & in_ready;
    piso_load  = (state == S_LOAD);
    piso_d     = piso_load ? hold_q : '0;
    shift_now  = (state == S_SHIFT) & ~tx_hold & ~abort;
    last_data  = (bit_cnt == CW'(WIDTH - 1));
    piso_shift = shift_now;
    busy       = (state != S_IDLE);
    word_count = wc_q;
    frame_start = shift_now & (bit_cnt == '0);
`ifdef PISO_TX_PARITY_EN
    par_now    = (state == S_PARITY) & ~tx_hold & ~abort;
    tx_valid   = shift_now | par_now;
    tx_bit     = (shift_now & piso_sout) | (par_now & (^hold_q));
    frame_done = par_now;
`else
    tx_valid   = shift_now;
    tx_bit     = shift_now & piso_sout;
    frame_done = shift_now & last_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      hold_q  <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      wc_q    <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (frame_done) begin
        wc_q <= wc_q + 16'd1;
      end
      case (state)
        S_IDLE: begin
          if (handshake) begin
            hold_q <= in_data;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (shift_now) begin
            if (last_data) begin
              bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
              state   <= S_PARITY;
`else
              gap_cnt <= '0;
              if (GAP_CYCLES > 0) state <= S_GAP;
              else                state <= S_IDLE;
`endif
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
`ifdef PISO_TX_PARITY_EN
        S_PARITY: begin
          if (par_now) begin
            gap_cnt <= '0;
            if (GAP_CYCLES > 0) state <= S_GAP;
            else                state <= S_IDLE;
          end
        end
`endif
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/piso_tx_ctrl.md
PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width and shift length (legal 2..32).
REQ-002 Parameter GAP_CYCLES, default 1, idle cycles inserted after each frame (0 = none).
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset.
REQ-005 Port in_data  input  WIDTH  parallel word to serialize.
REQ-006 Port in_valid  input  1  in_data valid.
REQ-007 Port in_ready  output  1  controller accepts word this cycle.
REQ-008 Port abort  input  1  drop current frame.
REQ-009 Port tx_hold  input  1  stall serialization.
REQ-010 Port piso_load  output  1  load strobe to shift register.
REQ-011 Port piso_d  output  WIDTH  word presented to shift register.
REQ-012 Port piso_shift  output  1  shift enable to shift register.
REQ-013 Port piso_sout  input  1  current serial bit (MSB) of shift register.
REQ-014 Port tx_bit  output  1  serial output bit.
REQ-015 Port tx_valid  output  1  tx_bit valid this cycle.
REQ-016 Port frame_start  output  1  one-cycle pulse with first tx_valid of a frame.
REQ-017 Port frame_done  output  1  one-cycle pulse with last tx_valid of a frame.
REQ-018 Port busy  output  1  high in any state except IDLE.
REQ-019 Port word_count  output  16  frames completed, wraps 0xFFFF->0.

Function
REQ-020 FSM states: IDLE, LOAD, SHIFT, PARITY (only when REQ-038 enabled), GAP.
REQ-021 in_ready = 1 only in IDLE; handshake = in_valid & in_ready; on handshake word captured into hold register, next state LOAD.
REQ-022 LOAD: exactly one cycle, piso_load=1, piso_d=held word, piso_shift=0, tx_valid=0; next SHIFT.
REQ-023 SHIFT: tx_bit=piso_sout (combinational), tx_valid=piso_shift=~tx_hold; bit counter increments per unheld cycle; MSB first.
REQ-024 SHIFT exits after exactly WIDTH unheld cycles; latency handshake->first tx_valid = 2 cycles with tx_hold low.
REQ-025 tx_hold in SHIFT/PARITY: freeze counter and state, tx_valid=0, piso_shift=0; no bit lost or repeated.
REQ-026 frame_start asserted with the first tx_valid; frame_done with the final tx_valid (last data bit, or parity bit if enabled).
REQ-027 After final bit: GAP for GAP_CYCLES cycles if GAP_CYCLES>0, else IDLE directly; in_ready therefore rises GAP_CYCLES+1 cycles after frame_done.
REQ-028 word_count increments on the cycle of frame_done; wraps silently.
REQ-029 abort in any non-IDLE state: next state IDLE, no frame_done, word_count unchanged, outputs idle next cycle; abort in IDLE ignored.
REQ-030 abort and tx_hold together: abort wins.
REQ-031 piso_load and piso_shift never asserted in the same cycle.
REQ-032 piso_d = 0 outside LOAD; tx_bit = 0 when tx_valid = 0.

Reset
REQ-033 reset low at a clock edge: state IDLE, counters 0, hold register 0 on that edge.
REQ-034 Reset values: in_ready=1 (after reset released), piso_load=0, piso_shift=0, piso_d=0, tx_bit=0, tx_valid=0, frame_start=0, frame_done=0, busy=0, word_count=0.
REQ-035 in_ready=0 while reset is low; handshake ignored.
REQ-036 Reset mid-frame discards the frame without frame_done.
REQ-037 Reset overrides abort, tx_hold and in_valid.

Configuration
REQ-038 Macro PISO_TX_PARITY_EN defined: after WIDTH data bits, one PARITY cycle emits even parity of held word on tx_bit with tx_valid=1, piso_shift=0; frame = WIDTH+1 bits.
REQ-039 Macro undefined: PARITY state and parity logic absent; frame = WIDTH bits.

Verification
REQ-040 Reset then in_data=8'hAA, in_valid=1 -> piso_load at cycle 1, tx_bit 1,0,1,0,1,0,1,0 cycles 2-9, frame_start@2, frame_done@9 (parity build: extra bit 0 @10, frame_done@10), word_count=1.
REQ-041 Back-to-back in_valid with 8'hFF then 8'h01, GAP_CYCLES=1 -> second in_ready exactly 2 cycles after first frame_done; second stream 0000_0001.
REQ-042 tx_hold high 3 cycles mid-SHIFT of 8'hC3 -> tx_valid gaps for 3 cycles, stream still 11000011, exactly 8 valid bits.
REQ-043 abort on 4th data bit -> IDLE next cycle, in_ready=1, no frame_done, word_count unchanged; abort+tx_hold same cycle behaves identically.
REQ-044 reset low mid-frame -> all outputs reset values next cycle; word_count preload 0xFFFF then one frame -> 0x0000.
